// File: rtl/cmd_pkg.sv
// Shared definitions for the DDR command queue: command codes,
// default field widths and the packed entry width helper.
package cmd_pkg;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    localparam int CMD_ADDR_W  = 27;
    localparam int CMD_BURST_W = 6;
    localparam int CMD_DATA_W  = 128;

    function automatic int entry_width(int aw, int bw, int dw, int chw);
        return 1 + aw + bw + dw + dw / 8 + chw;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock first-word-fall-through FIFO with inferred
// storage; pushes when full and pops when empty are ignored.
module sync_fifo_fwft #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cmd_arb_fifo.sv
// DDR front-end command queue: round-robin arbitration of NUM_CH
// requesters into one FWFT FIFO drained by the controller.
module cmd_arb_fifo
    import cmd_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int DEPTH     = 16,
    parameter  int ADDR_W    = CMD_ADDR_W,
    parameter  int BURST_W   = CMD_BURST_W,
    parameter  int DATA_W    = CMD_DATA_W,
    parameter  int AF_THRESH = DEPTH - 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MW        = DATA_W / 8,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int EW        = entry_width(ADDR_W, BURST_W, DATA_W, CH_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         push_valid,
    output logic [NUM_CH-1:0]         push_rdy,
    input  logic [NUM_CH-1:0]         push_cmd_type,
    input  logic [NUM_CH*ADDR_W-1:0]  push_addr,
    input  logic [NUM_CH*BURST_W-1:0] push_burst_cnt,
    input  logic [NUM_CH*DATA_W-1:0]  push_wt_data,
    input  logic [NUM_CH*MW-1:0]      push_wt_mask,
    output logic                      pop_valid,
    input  logic                      pop_rdy,
    output logic                      pop_cmd_type,
    output logic [ADDR_W-1:0]         pop_addr,
    output logic [BURST_W-1:0]        pop_burst_cnt,
    output logic [DATA_W-1:0]         pop_wt_data,
    output logic [MW-1:0]             pop_wt_mask,
    output logic [CH_W-1:0]           pop_ch,
    output logic [CW-1:0]             count,
    output logic                      almost_full
);

    logic [CH_W-1:0]   rr_q, rr_d;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              hit;
    int                idx;
    logic              full, empty, push_acc;
    logic [EW-1:0]     wr_entry, rd_entry;

    // Search upward from rr_q with wrap; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!hit && push_valid[idx]) begin
                hit      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = CH_W'(idx);
            end
        end
    end

    // Registered full only: no path from pop_rdy into push_rdy.
    assign push_rdy = gnt & {NUM_CH{~full}};
    assign push_acc = hit & ~full;

    always_comb begin
        rr_d = rr_q;
        if (push_acc) begin
            if (int'(gnt_idx) == NUM_CH - 1) rr_d = '0;
            else                             rr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

    assign wr_entry = {
        push_cmd_type[gnt_idx],
        push_addr[int'(gnt_idx)*ADDR_W +: ADDR_W],
        push_burst_cnt[int'(gnt_idx)*BURST_W +: BURST_W],
        push_wt_data[int'(gnt_idx)*DATA_W +: DATA_W],
        push_wt_mask[int'(gnt_idx)*MW +: MW],
        gnt_idx
    };

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc),
        .wdata (wr_entry),
        .pop   (pop_rdy),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign pop_valid   = ~empty;
    assign almost_full = (count >= CW'(AF_THRESH));

    assign {pop_cmd_type, pop_addr, pop_burst_cnt,
            pop_wt_data, pop_wt_mask, pop_ch} = rd_entry;

endmodule

// File: tb/tb_cmd_arb_fifo.sv
// Directed self-checking bench for cmd_arb_fifo (4 channels,
// 16 entries): vector table plus multi-cycle corner sequences.
module tb_cmd_arb_fifo;

    localparam int NCH = 4;
    localparam int AW  = 27;
    localparam int BW  = 6;
    localparam int DW  = 128;
    localparam int MW  = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  push_valid;
    logic [NCH-1:0]  push_rdy;
    logic [NCH-1:0]  push_cmd_type;
    logic [NCH*AW-1:0] push_addr;
    logic [NCH*BW-1:0] push_burst_cnt;
    logic [NCH*DW-1:0] push_wt_data;
    logic [NCH*MW-1:0] push_wt_mask;
    logic            pop_valid;
    logic            pop_rdy;
    logic            pop_cmd_type;
    logic [AW-1:0]   pop_addr;
    logic [BW-1:0]   pop_burst_cnt;
    logic [DW-1:0]   pop_wt_data;
    logic [MW-1:0]   pop_wt_mask;
    logic [1:0]      pop_ch;
    logic [4:0]      count;
    logic            almost_full;

    int errors = 0;
    int checks = 0;

    cmd_arb_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_rdy       (push_rdy),
        .push_cmd_type  (push_cmd_type),
        .push_addr      (push_addr),
        .push_burst_cnt (push_burst_cnt),
        .push_wt_data   (push_wt_data),
        .push_wt_mask   (push_wt_mask),
        .pop_valid      (pop_valid),
        .pop_rdy        (pop_rdy),
        .pop_cmd_type   (pop_cmd_type),
        .pop_addr       (pop_addr),
        .pop_burst_cnt  (pop_burst_cnt),
        .pop_wt_data    (pop_wt_data),
        .pop_wt_mask    (pop_wt_mask),
        .pop_ch         (pop_ch),
        .count          (count),
        .almost_full    (almost_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pv;
        logic       pr;
        logic [3:0] exp_rdy;
        logic       exp_pvld;
        logic [1:0] exp_ch;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_pay(input int ch, input logic t,
                           input logic [AW-1:0] a, input logic [BW-1:0] b);
        push_cmd_type[ch]           = t;
        push_addr[ch*AW +: AW]      = a;
        push_burst_cnt[ch*BW +: BW] = b;
        push_wt_data[ch*DW +: DW]   = {4{5'b0, a}};
        push_wt_mask[ch*MW +: MW]   = 16'hA5A5 ^ 16'(ch);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        push_valid = '0;
        pop_rdy    = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int nin, nout, k;
        logic [AW-1:0] a;

        push_cmd_type  = '0;
        push_addr      = '0;
        push_burst_cnt = '0;
        push_wt_data   = '0;
        push_wt_mask   = '0;
        for (int c = 0; c < NCH; c++) set_pay(c, 1'b0, AW'(32'h100 + c), BW'(c + 1));

        //        pv       pr    rdy      pvld  ch     cnt
        vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd0};
        vecs[1]  = '{4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 5'd0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 5'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 5'd1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 5'd1};
        vecs[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 5'd1};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 5'd1};
        vecs[7]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd0, 5'd1};
        vecs[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd2};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 5'd2};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 5'd1};
        vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd0};
        vecs[12] = '{4'b1001, 1'b0, 4'b1000, 1'b0, 2'd0, 5'd0};

        do_reset();
        chk("reset_almost_full", almost_full, 1'b0);
        for (int i = 0; i < 13; i++) begin
            push_valid = vecs[i].pv;
            pop_rdy    = vecs[i].pr;
            settle();
            chk($sformatf("vec%0d_push_rdy", i), push_rdy, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_pop_valid", i), pop_valid, vecs[i].exp_pvld);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
            if (vecs[i].exp_pvld) begin
                chk($sformatf("vec%0d_pop_ch", i), pop_ch, vecs[i].exp_ch);
                chk($sformatf("vec%0d_pop_addr", i), pop_addr,
                    AW'(32'h100 + vecs[i].exp_ch));
            end
            cyc();
        end

        // Single-channel fill then drain
        do_reset();
        for (k = 0; k < 16; k++) begin
            set_pay(2, 1'b0, AW'(32'h200 + k), BW'(k));
            push_valid = 4'b0100;
            settle();
            chk($sformatf("fill%0d_rdy", k), push_rdy, 4'b0100);
            chk($sformatf("fill%0d_count", k), count, 5'(k));
            chk($sformatf("fill%0d_af", k), almost_full, (k >= 14));
            cyc();
        end
        settle();
        chk("fill_full_rdy", push_rdy, 4'b0000);
        chk("fill_full_count", count, 5'd16);
        chk("fill_full_af", almost_full, 1'b1);
        push_valid = '0;
        pop_rdy    = 1'b1;
        for (k = 0; k < 16; k++) begin
            settle();
            chk($sformatf("drain%0d_valid", k), pop_valid, 1'b1);
            chk($sformatf("drain%0d_addr", k), pop_addr, AW'(32'h200 + k));
            chk($sformatf("drain%0d_burst", k), pop_burst_cnt, BW'(k));
            chk($sformatf("drain%0d_ch", k), pop_ch, 2'd2);
            cyc();
        end
        settle();
        chk("drain_empty", pop_valid, 1'b0);
        chk("drain_count", count, 5'd0);

        // Full with pop in progress
        do_reset();
        push_valid = 4'b0001;
        for (k = 0; k < 16; k++) begin
            set_pay(0, 1'b0, AW'(32'h300 + k), 6'd1);
            cyc();
        end
        set_pay(0, 1'b0, AW'(32'h3FF), 6'd1);
        pop_rdy = 1'b1;
        settle();
        chk("fullpop_c1_rdy", push_rdy, 4'b0000);
        chk("fullpop_c1_head", pop_addr, AW'(32'h300));
        cyc();
        settle();
        chk("fullpop_c1_count", count, 5'd15);
        chk("fullpop_c2_rdy", push_rdy, 4'b0001);
        cyc();
        push_valid = '0;
        settle();
        chk("fullpop_c2_count", count, 5'd15);
        for (k = 2; k < 16; k++) cyc();
        settle();
        chk("fullpop_tail_addr", pop_addr, AW'(32'h3FF));
        chk("fullpop_tail_count", count, 5'd1);

        // Wrap-around stream with toggling pop_rdy
        do_reset();
        nin  = 0;
        nout = 0;
        for (int c = 0; c < 300 && nout < 40; c++) begin
            set_pay(1, 1'b0, AW'(nin), 6'd2);
            push_valid = (nin < 40) ? 4'b0010 : 4'b0000;
            pop_rdy    = c[0];
            settle();
            if (pop_valid && pop_rdy) begin
                chk($sformatf("wrap_out%0d", nout), pop_addr, AW'(nout));
                nout++;
            end
            if (push_valid[1] && push_rdy[1]) nin++;
            cyc();
        end
        chk("wrap_all_out", 32'(nout), 32'd40);
        settle();
        chk("wrap_final_empty", pop_valid, 1'b0);

        // Empty latency
        do_reset();
        a = AW'(32'h1234567);
        set_pay(0, 1'b1, a, 6'd8);
        push_valid = 4'b0001;
        settle();
        chk("lat_push_cycle_valid", pop_valid, 1'b0);
        cyc();
        push_valid = '0;
        settle();
        chk("lat_next_valid", pop_valid, 1'b1);
        chk("lat_type", pop_cmd_type, 1'b1);
        chk("lat_addr", pop_addr, a);
        chk("lat_burst", pop_burst_cnt, 6'd8);
        chk("lat_data", pop_wt_data, {4{5'b0, a}});
        chk("lat_mask", pop_wt_mask, 16'hA5A5);
        chk("lat_ch", pop_ch, 2'd0);

        // Reset mid-operation with rr pointer moved off zero
        do_reset();
        push_valid = 4'b1000;
        for (k = 0; k < 4; k++) cyc();
        push_valid = 4'b0010;
        cyc();
        push_valid = '0;
        settle();
        chk("rstmid_pre_count", count, 5'd5);
        push_valid = 4'b1001;
        settle();
        chk("rstmid_pre_rdy", push_rdy, 4'b1000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        chk("rstmid_count", count, 5'd0);
        chk("rstmid_valid", pop_valid, 1'b0);
        chk("rstmid_rdy", push_rdy, 4'b0001);
        push_valid = '0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
